sd_spi_cmd_engine: RTL and testbench

SPI-mode SD card command engine on the peripheral side of the memory-mapped SD registers. It takes the 48-bit command word and start bit that firmware writes, and shifts the command out over SPI. It then polls for the R1 response and any trailing response bytes, returning each one as a byte plus a one-cycle strobe for the response register. It is the only block that drives the SD card pins.

---
 rtl/sd_spi_pkg.sv | 24 ++
 rtl/sd_crc7.sv | 22 ++
 rtl/sd_spi_cmd_engine.sv | 184 ++++++++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD command engine.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_POLL  = 3'd2,
        ST_TAIL  = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    localparam int         CMD_BITS   = 48;
    localparam logic [7:0] IDLE_BYTE  = 8'hFF;
    localparam logic [6:0] CRC7_POLY  = 7'h09;
    localparam int         FLUSH_BITS = 8;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data_bit);
        logic fb;
        fb = data_bit ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; used only when SD_CRC7_AUTO_EN is defined.
import sd_spi_pkg::*;

module sd_crc7 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            crc <= '0;
        else if (clear)
            crc <= '0;
        else if (enable)
            crc <= crc7_step(crc, data_bit);
    end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: sends a 48-bit command, polls R1 and trailing bytes.
// Optional build macro SD_CRC7_AUTO_EN replaces cmd[7:0] with a computed CRC7 + end bit.
import sd_spi_pkg::*;

module sd_spi_cmd_engine #(
    parameter int CLK_DIV  = 4,
    parameter int RESP_MAX = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [47:0] cmd,
    input  logic        start,
    input  logic [2:0]  extra_bytes,
    output logic        busy,
    output logic        resp_valid,
    output logic [7:0]  resp_byte,
    output logic        timeout,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int POLL_W = $clog2(RESP_MAX + 1);

    state_e            state;
    state_e            pend_state;
    logic              start_q;
    logic [47:0]       cmd_q;
    logic [2:0]        extra_cnt;
    logic [5:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [6:0]        rx;

    logic       tick, rise, fall, accept, byte_end, tx_bit;
    logic [5:0] nxt;
    logic [7:0] rx_byte;

    assign accept   = (state == ST_IDLE) && start && !start_q;
    assign tick     = (state != ST_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise     = tick && !spi_sclk;
    assign fall     = tick && spi_sclk;
    assign byte_end = (bit_cnt[2:0] == 3'(FLUSH_BITS - 1));
    assign nxt      = bit_cnt + 6'd1;
    assign rx_byte  = {rx, spi_miso};

`ifdef SD_CRC7_AUTO_EN
    logic [6:0] crc;

    sd_crc7 u_crc (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (accept),
        .enable   (rise && (state == ST_SEND) && (bit_cnt < 6'd40)),
        .data_bit (spi_mosi),
        .crc      (crc)
    );

    // Bits 40..46 come from the CRC accumulated over the first 40 bits; bit 47 is the end bit.
    always_comb begin
        tx_bit = 1'b1;
        if (nxt < 6'd40)
            tx_bit = cmd_q[6'd47 - nxt];
        else if (nxt < 6'd47)
            tx_bit = crc[3'd6 - 3'(nxt - 6'd40)];
    end
`else
    always_comb begin
        tx_bit = 1'b1;
        if (nxt <= 6'd47)
            tx_bit = cmd_q[6'd47 - nxt];
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pend_state <= ST_IDLE;
            start_q    <= 1'b0;
            cmd_q      <= '0;
            extra_cnt  <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            poll_cnt   <= '0;
            rx         <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_byte  <= IDLE_BYTE;
            timeout    <= 1'b0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b1;
            spi_cs_n   <= 1'b1;
        end else begin
            start_q    <= start;
            resp_valid <= 1'b0;
            timeout    <= 1'b0;

            if (tick) begin
                div_cnt  <= '0;
                spi_sclk <= ~spi_sclk;
            end else if (state != ST_IDLE) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q     <= cmd;
                        extra_cnt <= extra_bytes;
                        state     <= ST_SEND;
                        busy      <= 1'b1;
                        spi_cs_n  <= 1'b0;
                        spi_mosi  <= cmd[47];
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        poll_cnt  <= '0;
                    end
                end
                ST_SEND: begin
                    if (fall) begin
                        if (bit_cnt == 6'(CMD_BITS - 1)) begin
                            state    <= ST_POLL;
                            bit_cnt  <= '0;
                            spi_mosi <= 1'b1;
                        end else begin
                            bit_cnt  <= nxt;
                            spi_mosi <= tx_bit;
                        end
                    end
                end
                ST_POLL, ST_TAIL: begin
                    // Decide on the 8th rising sample, move on at the byte's closing falling edge.
                    if (rise) begin
                        rx <= rx_byte[6:0];
                        if (byte_end) begin
                            if (state == ST_TAIL) begin
                                resp_valid <= 1'b1;
                                resp_byte  <= rx_byte;
                                if (extra_cnt != 3'd0)
                                    extra_cnt <= extra_cnt - 3'd1;
                                pend_state <= (extra_cnt <= 3'd1) ? ST_FLUSH : ST_TAIL;
                            end else if (!rx_byte[7]) begin
                                resp_valid <= 1'b1;
                                resp_byte  <= rx_byte;
                                pend_state <= (extra_cnt != 3'd0) ? ST_TAIL : ST_FLUSH;
                            end else if (poll_cnt == POLL_W'(RESP_MAX - 1)) begin
                                resp_valid <= 1'b1;
                                timeout    <= 1'b1;
                                resp_byte  <= IDLE_BYTE;
                                pend_state <= ST_FLUSH;
                            end else begin
                                poll_cnt   <= poll_cnt + POLL_W'(1);
                                pend_state <= ST_POLL;
                            end
                        end
                    end
                    if (fall) begin
                        bit_cnt <= nxt;
                        if (byte_end) begin
                            state   <= pend_state;
                            bit_cnt <= '0;
                            if (pend_state == ST_FLUSH)
                                spi_cs_n <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fall) begin
                        bit_cnt <= nxt;
                        if (byte_end) begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Self-checking bench for sd_spi_cmd_engine with an SD card model and response reference model.
module tb_sd_spi_cmd_engine;

    localparam int CLK_DIV  = 2;
    localparam int RESP_MAX = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [47:0] cmd = '0;
    logic        start = 1'b0;
    logic [2:0]  extra_bytes = '0;
    logic        busy, resp_valid, timeout, spi_sclk, spi_mosi, spi_cs_n;
    logic [7:0]  resp_byte;
    logic        spi_miso = 1'b1;

    always #5 clock = ~clock;

    sd_spi_cmd_engine #(.CLK_DIV(CLK_DIV), .RESP_MAX(RESP_MAX)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd         (cmd),
        .start       (start),
        .extra_bytes (extra_bytes),
        .busy        (busy),
        .resp_valid  (resp_valid),
        .resp_byte   (resp_byte),
        .timeout     (timeout),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_cs_n    (spi_cs_n)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]  miso_bytes[$];
    logic        miso_bits[$];
    logic        mosi_bits[$];
    logic [7:0]  resp_q[$];
    logic        to_q[$];
    logic [7:0]  exp_resp[$];
    logic        exp_to[$];
    int          exp_n;
    logic [47:0] last_frame;
    int          flush_sclks = 0, cmd_count = 0, fall_cnt = 0, stray_to = 0;
    logic        sclk_prev = 1'b0, cs_prev = 1'b1;

    // Card model and bus monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (!busy) begin
            fall_cnt = 0;
            spi_miso = 1'b1;
        end
        if (spi_sclk && !sclk_prev) begin
            if (!spi_cs_n) mosi_bits.push_back(spi_mosi);
            else if (busy) flush_sclks++;
        end
        if (!spi_sclk && sclk_prev && !spi_cs_n) begin
            fall_cnt++;
            if (fall_cnt >= 48)
                spi_miso = (miso_bits.size() > 0) ? miso_bits.pop_front() : 1'b1;
        end
        if (!spi_cs_n && cs_prev) cmd_count++;
        if (resp_valid) begin
            resp_q.push_back(resp_byte);
            to_q.push_back(timeout);
        end else if (timeout) begin
            stray_to++;
        end
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int i);
        return (i < miso_bytes.size()) ? miso_bytes[i] : 8'hFF;
    endfunction

    // Expected wire frame: verbatim, or CRC7 over the first 40 bits plus end bit.
    function automatic logic [47:0] exp_frame(input logic [47:0] c);
`ifdef SD_CRC7_AUTO_EN
        logic [6:0] crc = 7'h00;
        logic       fb;
        for (int i = 47; i >= 8; i--) begin
            fb  = c[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return {c[47:8], crc, 1'b1};
`else
        return c;
`endif
    endfunction

    // Reference: first byte with bit7=0 within RESP_MAX bytes is R1, then x trailing bytes.
    task automatic model(input int x);
        int         i = 0;
        bit         found = 0;
        logic [7:0] b;
        exp_resp.delete();
        exp_to.delete();
        while (!found && i < RESP_MAX) begin
            b = get_byte(i);
            i++;
            if (!b[7]) begin
                found = 1;
                exp_resp.push_back(b);
                exp_to.push_back(1'b0);
            end
        end
        if (!found) begin
            exp_resp.push_back(8'hFF);
            exp_to.push_back(1'b1);
        end else begin
            for (int k = 0; k < x; k++) begin
                exp_resp.push_back(get_byte(i));
                exp_to.push_back(1'b0);
                i++;
            end
        end
        exp_n = i;
    endtask

    task automatic do_cmd(input string tag, input logic [47:0] c, input logic [2:0] x);
        logic [47:0] frame;
        int          cyc, t_exp, n;
        logic        rest_ok;
        model(int'(x));
        frame = exp_frame(c);
        t_exp = (48 + 8 * exp_n + 8) * 2 * CLK_DIV;
        miso_bits.delete();
        foreach (miso_bytes[i])
            for (int b = 7; b >= 0; b--) miso_bits.push_back(miso_bytes[i][b]);
        mosi_bits.delete();
        resp_q.delete();
        to_q.delete();
        flush_sclks = 0;
        stray_to    = 0;

        @(negedge clock);
        cmd = c;
        extra_bytes = x;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check({tag, ".busy_rise"}, busy, 1'b1);
        check({tag, ".cs_fall"}, spi_cs_n, 1'b0);
        cyc = 1;
        while (busy && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, ".busy_len"}, ((cyc - 1) == t_exp) || ((cyc - 1) == t_exp + 1), 1'b1);

        last_frame = '0;
        for (int i = 0; i < 48 && i < mosi_bits.size(); i++)
            last_frame[47 - i] = mosi_bits[i];
        rest_ok = 1'b1;
        for (int i = 48; i < mosi_bits.size(); i++)
            if (mosi_bits[i] !== 1'b1) rest_ok = 1'b0;
        check({tag, ".mosi_bits"}, mosi_bits.size(), 48 + 8 * exp_n);
        check({tag, ".mosi_frame"}, last_frame, frame);
        check({tag, ".mosi_idle_ff"}, rest_ok, 1'b1);

        check({tag, ".resp_count"}, resp_q.size(), exp_resp.size());
        n = (resp_q.size() < exp_resp.size()) ? resp_q.size() : exp_resp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.resp%0d", tag, i), resp_q[i], exp_resp[i]);
            check($sformatf("%s.to%0d", tag, i), to_q[i], exp_to[i]);
        end
        check({tag, ".stray_timeout"}, stray_to, 0);
        check({tag, ".flush_sclks"}, flush_sclks, 8);
        check({tag, ".idle_cs"}, spi_cs_n, 1'b1);
        check({tag, ".idle_sclk"}, spi_sclk, 1'b0);
    endtask

    initial begin
        int          c0, cyc;
        logic [47:0] rc;
        logic [2:0]  rx;
        int          nff;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst.busy", busy, 1'b0);
        check("rst.resp_valid", resp_valid, 1'b0);
        check("rst.timeout", timeout, 1'b0);
        check("rst.resp_byte", resp_byte, 8'hFF);
        check("rst.sclk", spi_sclk, 1'b0);
        check("rst.mosi", spi_mosi, 1'b1);
        check("rst.cs_n", spi_cs_n, 1'b1);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // CMD0 with R1 on the third poll byte
        miso_bytes = '{8'hFF, 8'hFF, 8'h01};
        do_cmd("cmd0", 48'h400000000095, 3'd0);
        check("cmd0.frame_const", last_frame, 48'h400000000095);
        check("cmd0.one_resp", resp_q.size(), 1);
        if (resp_q.size() > 0) check("cmd0.r1_const", resp_q[0], 8'h01);
        check("cmd0.busy_low", busy, 1'b0);

        // Timeout: card never answers
        miso_bytes.delete();
        do_cmd("tmo", 48'h7A0000000001, 3'd0);
        if (resp_q.size() > 0) begin
            check("tmo.byte_const", resp_q[0], 8'hFF);
            check("tmo.flag_const", to_q[0], 1'b1);
        end else check("tmo.have_resp", resp_q.size(), 1);

        // CMD8 with R7 trailing bytes
        miso_bytes = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        do_cmd("cmd8", 48'h48000001AA87, 3'd4);
        check("cmd8.five_resp", resp_q.size(), 5);
        if (resp_q.size() == 5) begin
            check("cmd8.b0", resp_q[0], 8'h01);
            check("cmd8.b3", resp_q[3], 8'h01);
            check("cmd8.b4", resp_q[4], 8'hAA);
        end

        // CRC7 substitution (or verbatim) on the last byte
        miso_bytes = '{8'h01};
        do_cmd("crc", 48'h48000001AA00, 3'd0);
`ifdef SD_CRC7_AUTO_EN
        check("crc.last_byte", last_frame[7:0], 8'h87);
`else
        check("crc.last_byte", last_frame[7:0], 8'h00);
`endif

        // start held high across several command durations sends only one command
        miso_bytes.delete();
        miso_bits.delete();
        c0 = cmd_count;
        @(negedge clock);
        cmd = 48'h4C0000000001;
        extra_bytes = 3'd0;
        start = 1'b1;
        repeat (1500) @(negedge clock);
        check("hold.one_cmd", cmd_count - c0, 1);
        check("hold.idle", busy, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        repeat (2) @(negedge clock);
        check("hold.second_cmd", cmd_count - c0, 2);
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check("hold.second_done", busy, 1'b0);

        // Asynchronous reset in the middle of SEND
        mosi_bits.delete();
        @(negedge clock);
        cmd = 48'h5100000000FF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (mosi_bits.size() < 20 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check("arst.reached_bit20", mosi_bits.size() >= 20, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst.cs_n", spi_cs_n, 1'b1);
        check("arst.sclk", spi_sclk, 1'b0);
        check("arst.busy", busy, 1'b0);
        check("arst.mosi", spi_mosi, 1'b1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        c0 = cmd_count;
        repeat (200) @(negedge clock);
        check("arst.no_activity", cmd_count - c0, 0);
        check("arst.still_idle", busy, 1'b0);

        // Randomized commands against the reference model
        for (int it = 0; it < 10; it++) begin
            rc  = {2'b01, 6'($urandom), 32'($urandom), 8'($urandom)};
            rx  = 3'($urandom_range(0, 4));
            nff = $urandom_range(0, RESP_MAX);
            miso_bytes.delete();
            for (int k = 0; k < nff; k++) miso_bytes.push_back(8'hFF);
            miso_bytes.push_back(8'($urandom) & 8'h7F);
            for (int k = 0; k < 4; k++) miso_bytes.push_back(8'($urandom));
            do_cmd($sformatf("rnd%0d", it), rc, rx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
